// File: rtl/execute_stage_if.sv
// EX stage port bundle: ID/EX inputs, forwarding, EX/MEM outputs.
// master drives ID/EX side, slave is the execute stage.
interface execute_stage_if #(
  parameter int XLEN = 32
);
  logic            id_ex_valid;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [XLEN-1:0] id_ex_imm;
  logic            id_ex_alu_src;
  logic [3:0]      id_ex_alu_op;
  logic [4:0]      id_ex_rd;
  logic            id_ex_RegWrite;
  logic            id_ex_MemRead;
  logic            id_ex_MemWrite;
  logic [1:0]      ForwardA;
  logic [1:0]      ForwardB;
  logic [XLEN-1:0] ex_mem_fwd_data;
  logic [XLEN-1:0] mem_wb_fwd_data;
  logic            flush;
  logic            mem_stall;
  logic            ex_busy;
  logic            ex_mem_valid;
  logic            ex_mem_RegWrite;
  logic            ex_mem_MemRead;
  logic            ex_mem_MemWrite;
  logic [XLEN-1:0] ex_mem_alu_result;
  logic [XLEN-1:0] ex_mem_store_data;
  logic [4:0]      ex_mem_rd;

  modport master (
    output id_ex_valid, id_ex_rs1_data,
    output id_ex_rs2_data, id_ex_imm,
    output id_ex_alu_src, id_ex_alu_op,
    output id_ex_rd, id_ex_RegWrite,
    output id_ex_MemRead, id_ex_MemWrite,
    output ForwardA, ForwardB,
    output ex_mem_fwd_data, mem_wb_fwd_data,
    output flush, mem_stall,
    input  ex_busy, ex_mem_valid,
    input  ex_mem_RegWrite, ex_mem_MemRead,
    input  ex_mem_MemWrite, ex_mem_alu_result,
    input  ex_mem_store_data, ex_mem_rd
  );

  modport slave (
    input  id_ex_valid, id_ex_rs1_data,
    input  id_ex_rs2_data, id_ex_imm,
    input  id_ex_alu_src, id_ex_alu_op,
    input  id_ex_rd, id_ex_RegWrite,
    input  id_ex_MemRead, id_ex_MemWrite,
    input  ForwardA, ForwardB,
    input  ex_mem_fwd_data, mem_wb_fwd_data,
    input  flush, mem_stall,
    output ex_busy, ex_mem_valid,
    output ex_mem_RegWrite, ex_mem_MemRead,
    output ex_mem_MemWrite, ex_mem_alu_result,
    output ex_mem_store_data, ex_mem_rd
  );
endinterface

// File: rtl/execute_stage.sv
// EX stage: forwarding muxes, ALU, shift-add multiplier, EX/MEM reg.
// Define EX_MULHU_EN to enable iterative MULHU (op 11).
module execute_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  execute_stage_if.slave bus
);
  localparam int CW = $clog2(XLEN);
`ifdef EX_MULHU_EN
  localparam int AW = 2 * XLEN;
`else
  localparam int AW = XLEN;
`endif

  typedef enum logic {IDLE, MUL} state_t;

  typedef struct packed {
    logic            valid;
    logic            rw;
    logic            mr;
    logic            mw;
    logic [4:0]      rd;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] st;
  } exm_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   mcand, acc, acc_nx;
  logic [XLEN-1:0] mplier, st_q, prod;
  logic [4:0]      rd_q;
  logic            rw_q, mr_q, mw_q;
`ifdef EX_MULHU_EN
  logic            hi_q;
`endif

  logic [XLEN-1:0] op_a, fwd_b, alu_b, alu_y;
  logic [CW-1:0]   shamt;
  logic            is_mul, start, busy_c, ld;
  exm_t            nx, q;

  function automatic logic [XLEN-1:0] fsel(
    input logic [1:0]      f,
    input logic [XLEN-1:0] rf,
    input logic [XLEN-1:0] ex,
    input logic [XLEN-1:0] wb
  );
    case (f)
      2'b10:   return ex;
      2'b01:   return wb;
      default: return rf;
    endcase
  endfunction

  assign op_a  = fsel(bus.ForwardA, bus.id_ex_rs1_data,
                      bus.ex_mem_fwd_data,
                      bus.mem_wb_fwd_data);
  assign fwd_b = fsel(bus.ForwardB, bus.id_ex_rs2_data,
                      bus.ex_mem_fwd_data,
                      bus.mem_wb_fwd_data);
  assign alu_b = bus.id_ex_alu_src ? bus.id_ex_imm : fwd_b;
  assign shamt = alu_b[CW-1:0];

`ifdef EX_MULHU_EN
  assign is_mul = (bus.id_ex_alu_op == 4'd10) ||
                  (bus.id_ex_alu_op == 4'd11);
`else
  assign is_mul = (bus.id_ex_alu_op == 4'd10);
`endif
  assign start = bus.id_ex_valid && is_mul;

  always_comb begin
    alu_y = '0;
    case (bus.id_ex_alu_op)
      4'd0: alu_y = op_a + alu_b;
      4'd1: alu_y = op_a - alu_b;
      4'd2: alu_y = op_a & alu_b;
      4'd3: alu_y = op_a | alu_b;
      4'd4: alu_y = op_a ^ alu_b;
      4'd5: alu_y = op_a << shamt;
      4'd6: alu_y = op_a >> shamt;
      4'd7: alu_y = $signed(op_a) >>> shamt;
      4'd8: alu_y = {{(XLEN-1){1'b0}},
                     $signed(op_a) < $signed(alu_b)};
      4'd9: alu_y = {{(XLEN-1){1'b0}}, op_a < alu_b};
      default: alu_y = '0;
    endcase
  end

  // final partial product folds in during the counter==0 cycle
  assign acc_nx = mplier[0] ? acc + mcand : acc;
`ifdef EX_MULHU_EN
  assign prod = hi_q ? acc_nx[AW-1:XLEN]
                     : acc_nx[XLEN-1:0];
`else
  assign prod = acc_nx;
`endif

  always_comb begin
    busy_c = 1'b0;
    if (bus.flush)          busy_c = 1'b0;
    else if (bus.mem_stall) busy_c = 1'b1;
    else if (state == MUL)  busy_c = (cnt != '0);
    else                    busy_c = start;
  end
  assign bus.ex_busy = rst_n && busy_c;

  always_comb begin
    nx = '0;
    ld = 1'b0;
    if (bus.flush) begin
      ld = 1'b1;
    end else if (!bus.mem_stall) begin
      ld = 1'b1;
      if (state == IDLE && !start) begin
        nx = '{bus.id_ex_valid, bus.id_ex_RegWrite,
               bus.id_ex_MemRead, bus.id_ex_MemWrite,
               bus.id_ex_rd, alu_y, fwd_b};
      end else if (state == MUL && cnt == '0) begin
        nx = '{1'b1, rw_q, mr_q, mw_q, rd_q, prod, st_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      st_q   <= '0;
      rd_q   <= '0;
      rw_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
`ifdef EX_MULHU_EN
      hi_q   <= 1'b0;
`endif
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (!bus.mem_stall) begin
      case (state)
        IDLE: if (start) begin
          state  <= MUL;
          cnt    <= CW'(XLEN - 1);
          mcand  <= AW'(op_a);
          mplier <= alu_b;
          acc    <= '0;
          st_q   <= fwd_b;
          rd_q   <= bus.id_ex_rd;
          rw_q   <= bus.id_ex_RegWrite;
          mr_q   <= bus.id_ex_MemRead;
          mw_q   <= bus.id_ex_MemWrite;
`ifdef EX_MULHU_EN
          hi_q   <= (bus.id_ex_alu_op == 4'd11);
`endif
        end
        MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (ld) q <= nx;
  end

  assign bus.ex_mem_valid      = q.valid;
  assign bus.ex_mem_RegWrite   = q.rw;
  assign bus.ex_mem_MemRead    = q.mr;
  assign bus.ex_mem_MemWrite   = q.mw;
  assign bus.ex_mem_rd         = q.rd;
  assign bus.ex_mem_alu_result = q.res;
  assign bus.ex_mem_store_data = q.st;
endmodule
